// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared types and constants for the FMA alignment shifter
package fma_pkg;

  localparam int ALN_GUARD = 1;

  localparam int DEF_LANES = 4;
  localparam int DEF_ACCW  = 48;
  localparam int DEF_SFTW  = 6;

  typedef struct packed {
    logic                            en;
    logic [DEF_LANES-1:0]            lane_en;
    logic [DEF_LANES-1:0]            neg;
    logic [DEF_LANES*DEF_ACCW-1:0]   acc;
    logic [DEF_LANES*DEF_SFTW-1:0]   sft;
  } sftpit;

  typedef struct packed {
    logic [DEF_LANES*DEF_ACCW-1:0]               acco;
    logic [DEF_LANES*(DEF_ACCW+ALN_GUARD)-1:0]   aln;
    logic [DEF_LANES-1:0]                        sticky;
  } sftpot;

endpackage

// File: rtl/alnsft_lane.sv
// rtl/alnsft_lane.sv - one lane of coarse/fine right shift with sticky generation
module alnsft_lane
  import fma_pkg::*;
#(
  parameter int ACCW = 48,
  parameter int SFTW = 6
) (
  input  logic [ACCW-1:0]           acc,
  input  logic [SFTW-4:0]           sft_hi,
  output logic [ACCW+ALN_GUARD-1:0] part,
  output logic                      part_sticky,
  input  logic [ACCW+ALN_GUARD-1:0] part_q,
  input  logic                      part_sticky_q,
  input  logic [2:0]                sft_lo,
  input  logic                      neg,
  input  logic                      en,
  output logic [ACCW+ALN_GUARD-1:0] aln,
  output logic                      sticky
);

  localparam int W = ACCW + ALN_GUARD;

  logic [W-1:0]    ext;
  logic [SFTW-1:0] coarse_amt;
  logic [2*W-1:0]  coarse_win;
  logic [W+7:0]    fine_win;

  assign ext        = {acc, {ALN_GUARD{1'b0}}};
  assign coarse_amt = {sft_hi, 3'b000};

  // The low half of the double-width window collects every bit shifted out.
  always_comb begin
    coarse_win  = {ext, {W{1'b0}}} >> coarse_amt;
    part        = coarse_win[2*W-1:W];
    part_sticky = |coarse_win[W-1:0];
    if (int'(coarse_amt) >= W) begin
      part        = '0;
      part_sticky = |acc;
    end
  end

  always_comb begin
    fine_win = {part_q, 8'h00} >> sft_lo;
    aln      = '0;
    sticky   = 1'b0;
    if (en) begin
      aln    = neg ? ~fine_win[W+7:8] : fine_win[W+7:8];
      sticky = part_sticky_q | (|fine_win[7:0]);
    end
  end

endmodule

// File: rtl/alnsft_pipe.sv
// rtl/alnsft_pipe.sv - two-stage multi-lane alignment shifter with valid/ready flow control
module alnsft_pipe
  import fma_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACCW  = 48,
  parameter int SFTW  = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0]                  lane_en,
  input  logic [LANES-1:0]                  neg,
  input  logic [LANES*ACCW-1:0]             acc,
  input  logic [LANES*SFTW-1:0]             sft,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*ACCW-1:0]             acco,
  output logic [LANES*(ACCW+ALN_GUARD)-1:0] aln,
  output logic [LANES-1:0]                  sticky
);

  localparam int W = ACCW + ALN_GUARD;

  logic v1, v2, ld1, ld2;

  logic [LANES*W-1:0]    part_d, s1_part, aln_d;
  logic [LANES-1:0]      part_sticky_d, s1_sticky, s1_neg, s1_en, sticky_d;
  logic [LANES*3-1:0]    sft_lo_d, s1_lo;
  logic [LANES*ACCW-1:0] s1_acc, acco_d;

  assign ld2       = !v2 || out_ready;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v2;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign sft_lo_d[i*3 +: 3]  = sft[i*SFTW +: 3];
      assign acco_d[i*ACCW +: ACCW] = s1_en[i] ? s1_acc[i*ACCW +: ACCW] : '0;

      alnsft_lane #(
        .ACCW (ACCW),
        .SFTW (SFTW)
      ) u_lane (
        .acc           (acc[i*ACCW +: ACCW]),
        .sft_hi        (sft[i*SFTW+3 +: SFTW-3]),
        .part          (part_d[i*W +: W]),
        .part_sticky   (part_sticky_d[i]),
        .part_q        (s1_part[i*W +: W]),
        .part_sticky_q (s1_sticky[i]),
        .sft_lo        (s1_lo[i*3 +: 3]),
        .neg           (s1_neg[i]),
        .en            (s1_en[i]),
        .aln           (aln_d[i*W +: W]),
        .sticky        (sticky_d[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
    end
  end

  // Coarse stage: data only moves on an accepted input, so a stalled stage holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_part   <= '0;
      s1_sticky <= '0;
      s1_lo     <= '0;
      s1_neg    <= '0;
      s1_en     <= '0;
      s1_acc    <= '0;
    end else if (ld1 && in_valid) begin
      s1_part   <= part_d;
      s1_sticky <= part_sticky_d;
      s1_lo     <= sft_lo_d;
      s1_neg    <= neg;
      s1_en     <= lane_en;
      s1_acc    <= acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aln    <= '0;
      sticky <= '0;
      acco   <= '0;
    end else if (ld2 && v1) begin
      aln    <= aln_d;
      sticky <= sticky_d;
      acco   <= acco_d;
    end
  end

endmodule

// File: tb/tb_alnsft_pipe.sv
// tb/tb_alnsft_pipe.sv - directed vector, flow-control and parameter-sweep bench for alnsft_pipe
`timescale 1ns/1ps
module tb_alnsft_pipe;

  localparam int L  = 4;
  localparam int A  = 48;
  localparam int S  = 6;
  localparam int W  = A + 1;
  localparam int SA = 24;
  localparam int SW = SA + 1;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, out_valid, out_ready;
  logic [L-1:0]   lane_en, neg, sticky;
  logic [L*A-1:0] acc, acco;
  logic [L*S-1:0] sft;
  logic [L*W-1:0] aln;

  alnsft_pipe #(.LANES(L), .ACCW(A), .SFTW(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .lane_en(lane_en), .neg(neg), .acc(acc), .sft(sft),
    .out_valid(out_valid), .out_ready(out_ready),
    .acco(acco), .aln(aln), .sticky(sticky)
  );

  logic            p_valid;
  logic            p8_ready, p8_ovalid, p1_ready, p1_ovalid;
  logic [7:0]      en8, neg8, st8;
  logic [8*SA-1:0] acc8, acco8;
  logic [8*S-1:0]  sft8;
  logic [8*SW-1:0] aln8;
  logic [0:0]      en1, neg1, st1;
  logic [SA-1:0]   acc1, acco1;
  logic [S-1:0]    sft1;
  logic [SW-1:0]   aln1;

  alnsft_pipe #(.LANES(8), .ACCW(SA), .SFTW(S)) dut8 (
    .clk(clk), .reset(reset), .in_valid(p_valid), .in_ready(p8_ready),
    .lane_en(en8), .neg(neg8), .acc(acc8), .sft(sft8),
    .out_valid(p8_ovalid), .out_ready(1'b1),
    .acco(acco8), .aln(aln8), .sticky(st8)
  );

  alnsft_pipe #(.LANES(1), .ACCW(SA), .SFTW(S)) dut1 (
    .clk(clk), .reset(reset), .in_valid(p_valid), .in_ready(p1_ready),
    .lane_en(en1), .neg(neg1), .acc(acc1), .sft(sft1),
    .out_valid(p1_ovalid), .out_ready(1'b1),
    .acco(acco1), .aln(aln1), .sticky(st1)
  );

  typedef struct packed {
    logic [L-1:0]         en;
    logic [L-1:0]         ng;
    logic [L-1:0][A-1:0]  a;
    logic [L-1:0][S-1:0]  s;
    logic [L-1:0][W-1:0]  ea;
    logic [L-1:0]         es;
  } vec_t;

  vec_t vt [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int v, input int l, input logic [A-1:0] a,
                          input logic [S-1:0] s, input logic [W-1:0] ea, input logic es);
    vt[v].a[l]  = a;
    vt[v].s[l]  = s;
    vt[v].ea[l] = ea;
    vt[v].es[l] = es;
  endtask

  function automatic void ref_lane(input logic [63:0] a, input int w, input logic [5:0] s,
                                   input logic e, input logic n,
                                   output logic [63:0] r, output logic st);
    logic [63:0] ex;
    ex = a << 1;
    r  = ex >> s;
    st = |(ex & ((64'd1 << s) - 64'd1));
    if (n) r = ~r;
    r = r & ((64'd1 << (w + 1)) - 64'd1);
    if (!e) begin
      r  = '0;
      st = 1'b0;
    end
  endfunction

  logic [L*W-1:0] bp_exp [5];
  logic [L*W-1:0] held;
  logic [L*A-1:0] exp_acco;
  logic [63:0]    r;
  logic           rs;
  int sent, recv, last, lat;
  logic saw_full, stall, any_valid;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    lane_en = '0; neg = '0; acc = '0; sft = '0;
    p_valid = 1'b0; en8 = '0; neg8 = '0; acc8 = '0; sft8 = '0;
    en1 = '0; neg1 = '0; acc1 = '0; sft1 = '0;

    vt[0].en = 4'b1111; vt[0].ng = 4'b0000;
    set_lane(0, 0, 48'h8000_0000_0000, 6'd0,  49'h1_0000_0000_0000, 1'b0);
    set_lane(0, 1, 48'h8000_0000_0000, 6'd9,  49'h0_0080_0000_0000, 1'b0);
    set_lane(0, 2, 48'h1,              6'd2,  49'h0,                1'b1);
    set_lane(0, 3, 48'hFFFF_FFFF_FFFF, 6'd63, 49'h0,                1'b1);
    vt[1].en = 4'b1111; vt[1].ng = 4'b0001;
    set_lane(1, 0, 48'h1,              6'd0,  49'h1_FFFF_FFFF_FFFD, 1'b0);
    set_lane(1, 1, 48'hFF,             6'd8,  49'h1,                1'b1);
    set_lane(1, 2, 48'h1234_5678_9ABC, 6'd4,  49'h0_0246_8ACF_1357, 1'b1);
    set_lane(1, 3, 48'hFFFF_FFFF_FFFF, 6'd49, 49'h0,                1'b1);
    vt[2].en = 4'b0101; vt[2].ng = 4'b1111;
    set_lane(2, 0, 48'h10,             6'd3,  49'h1_FFFF_FFFF_FFFB, 1'b0);
    set_lane(2, 1, 48'hFFFF_FFFF_FFFF, 6'd5,  49'h0,                1'b0);
    set_lane(2, 2, 48'hFFFF_FFFF_FFFF, 6'd48, 49'h1_FFFF_FFFF_FFFE, 1'b1);
    set_lane(2, 3, 48'h1234,           6'd0,  49'h0,                1'b0);
    vt[3].en = 4'b1111; vt[3].ng = 4'b0000;
    set_lane(3, 0, 48'h8000_0000_0001, 6'd8,  49'h0_0100_0000_0000, 1'b1);
    set_lane(3, 1, 48'h0,              6'd63, 49'h0,                1'b0);
    set_lane(3, 2, 48'h80,             6'd8,  49'h1,                1'b0);
    set_lane(3, 3, 48'hFFFF_FFFF_FFFF, 6'd7,  49'h0_03FF_FFFF_FFFF, 1'b1);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_aln", aln, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_acco", acco, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lane_en = vt[k].en; neg = vt[k].ng; acc = vt[k].a; sft = vt[k].s;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("vec%0d_latency", k), lat, 2);
      chk($sformatf("vec%0d_aln", k), aln, vt[k].ea);
      chk($sformatf("vec%0d_sticky", k), sticky, vt[k].es);
      for (int l = 0; l < L; l++)
        exp_acco[l*A +: A] = vt[k].en[l] ? vt[k].a[l] : '0;
      chk($sformatf("vec%0d_acco", k), acco, exp_acco);
    end

    for (int k = 0; k < 5; k++)
      for (int l = 0; l < L; l++)
        bp_exp[k][l*W +: W] = {8'(k + 1), 32'h0, 8'(l), 1'b0};
    sent = 0; recv = 0; last = -1; saw_full = 1'b0; stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 5);
      lane_en   = 4'b1111; neg = '0; sft = '0;
      for (int l = 0; l < L; l++)
        acc[l*A +: A] = {8'(sent + 1), 32'h0, 8'(l)};
      #1;
      chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, ((sent - recv) < 2) || out_ready);
      if (!in_ready) saw_full = 1'b1;
      if (stall) chk($sformatf("bp_stable_c%0d", cyc), aln, held);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_order_%0d", recv), aln, bp_exp[recv]);
        recv++;
        last = cyc;
      end
      stall = out_valid && !out_ready;
      held  = aln;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_saw_full", saw_full, 1);
    chk("bp_count", recv, 5);
    chk("bp_last_cycle", last, 9);

    @(negedge clk);
    in_valid = 1'b1; acc = {L{48'hABCD}}; lane_en = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_aln", aln, 0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    chk("midrst_no_stale", any_valid, 0);

    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      for (int l = 0; l < 8; l++) begin
        en8[l]  = ($urandom_range(0, 9) != 0);
        neg8[l] = $urandom_range(0, 1) == 1;
        acc8[l*SA +: SA] = SA'($urandom);
        sft8[l*S +: S] = (it % 4 == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, SW));
      end
      en1  = 1'($urandom_range(0, 1) | (it < 10 ? 1 : 0));
      neg1 = 1'($urandom_range(0, 1));
      acc1 = SA'($urandom);
      sft1 = 6'($urandom_range(0, 63));
      p_valid = 1'b1;
      #1;
      chk($sformatf("sw%0d_in_ready", it), p8_ready && p1_ready, 1);
      @(negedge clk);
      p_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("sw%0d_out_valid", it), p8_ovalid && p1_ovalid, 1);
      for (int l = 0; l < 8; l++) begin
        ref_lane(64'(acc8[l*SA +: SA]), SA, sft8[l*S +: S], en8[l], neg8[l], r, rs);
        chk($sformatf("sw%0d_l8_%0d_aln", it, l), aln8[l*SW +: SW], r[SW-1:0]);
        chk($sformatf("sw%0d_l8_%0d_sticky", it, l), st8[l], rs);
        chk($sformatf("sw%0d_l8_%0d_acco", it, l), acco8[l*SA +: SA], en8[l] ? acc8[l*SA +: SA] : '0);
      end
      ref_lane(64'(acc1), SA, sft1, en1[0], neg1[0], r, rs);
      chk($sformatf("sw%0d_l1_aln", it), aln1, r[SW-1:0]);
      chk($sformatf("sw%0d_l1_sticky", it), st1, rs);
      chk($sformatf("sw%0d_l1_acco", it), acco1, en1[0] ? acc1 : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
